// File: rtl/risc_v_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module  : risc_v_trace_pkg
// Brief   : Shared types and constants for the RISC-V trace UART.
// Revision: 1.0 - initial release
// ============================================================================
package risc_v_trace_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } ser_state_t;

    localparam logic [7:0] SYNC_BYTE     = 8'hA5;
    localparam int         REC_W         = 64;
    localparam int         BYTES_PER_REC = 9;

    // Byte 0 is the sync marker, bytes 1..8 walk the record MSB first.
    function automatic logic [7:0] rec_byte(input logic [REC_W-1:0] rec,
                                            input logic [3:0]       idx);
        logic [7:0] b;
        case (idx)
            4'd1:    b = rec[63:56];
            4'd2:    b = rec[55:48];
            4'd3:    b = rec[47:40];
            4'd4:    b = rec[39:32];
            4'd5:    b = rec[31:24];
            4'd6:    b = rec[23:16];
            4'd7:    b = rec[15:8];
            4'd8:    b = rec[7:0];
            default: b = SYNC_BYTE;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/risc_v_trace_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module  : trace_fifo
// Brief   : First-word fall-through record FIFO; push accepted when full if
//           a pop happens on the same edge.
// Revision: 1.0 - initial release
// ============================================================================
module trace_fifo
    import risc_v_trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic [REC_W-1:0] din,
    output logic [REC_W-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int         AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] c_full_cnt = (AW + 1)'(DEPTH);

    logic [REC_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);
    assign full   = (r_count == c_full_cnt);
    assign empty  = (r_count == '0);
    assign dout   = r_mem[r_rd_ptr];

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/risc_v_trace_uart.sv
`default_nettype none
// ============================================================================
// Module  : risc_v_trace_uart
// Brief   : Captures {PC, INST_DATA} trace records and streams them out as
//           9-byte 8N1 UART packets, counting records lost to overflow.
// Revision: 1.0 - initial release
// ============================================================================
module risc_v_trace_uart
    import risc_v_trace_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        TRACE_EN,
    input  logic [31:0] PC,
    input  logic [31:0] INST_DATA,
    output logic        UART_TX,
    output logic        TX_BUSY,
    output logic        OVF,
    output logic [7:0]  DROP_CNT
);

    localparam logic [15:0] c_bit_last  = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  c_last_byte = 4'(BYTES_PER_REC - 1);

    ser_state_t       r_state;
    logic [15:0]      r_bit_cnt;
    logic [2:0]       r_bit_idx;
    logic [3:0]       r_byte_idx;
    logic [REC_W-1:0] r_rec;
    logic             r_tx;
    logic             r_busy;
    logic             r_ovf;
    logic [7:0]       r_drop_cnt;

    logic [REC_W-1:0] w_fifo_dout;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_drop;
    logic             w_bit_end;
    logic [7:0]       w_cur_byte;
    logic [2:0]       w_next_bit;

    assign w_pop      = (r_state == IDLE) && !w_empty;
    assign w_drop     = TRACE_EN && w_full && !w_pop;
    assign w_bit_end  = (r_bit_cnt == c_bit_last);
    assign w_cur_byte = rec_byte(r_rec, r_byte_idx);
    assign w_next_bit = r_bit_idx + 3'd1;

    trace_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (TRACE_EN),
        .pop   (w_pop),
        .din   ({PC, INST_DATA}),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    // UART_TX and TX_BUSY are registered with the state so they change on the
    // same edge as the state transition that implies them.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_rec      <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (!w_empty) begin
                        r_rec      <= w_fifo_dout;
                        r_byte_idx <= '0;
                        r_bit_cnt  <= '0;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= w_cur_byte[0];
                        r_state   <= DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= w_next_bit;
                            r_tx      <= w_cur_byte[w_next_bit];
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= '0;
                        if (r_byte_idx < c_last_byte) begin
                            r_byte_idx <= r_byte_idx + 4'd1;
                            r_tx       <= 1'b0;
                            r_state    <= START;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 16'd1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign UART_TX  = r_tx;
    assign TX_BUSY  = r_busy;
    assign OVF      = r_ovf;
    assign DROP_CNT = r_drop_cnt;

endmodule
`default_nettype wire
